// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the final-layer operand loader.
package bnn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      LOAD_D = 2'd2,
      HOLD   = 2'd3
   } loader_state_t;

   localparam int NUM_INPUTS_DEF  = 196;
   localparam int NUM_NEURONS_DEF = 10;

   // Number of stream bytes needed to cover a field of the given width.
   function automatic int bytes_for(input int bits);
      return (bits + 7) / 8;
   endfunction

   // Valid bits in the last byte of a field; 0 means the last byte is full.
   function automatic int tail_bits(input int bits);
      return bits % 8;
   endfunction

   localparam int W_BYTES     = bytes_for(NUM_INPUTS_DEF * NUM_NEURONS_DEF);
   localparam int D_BYTES     = bytes_for(NUM_INPUTS_DEF);
   localparam int W_TAIL_BITS = tail_bits(NUM_INPUTS_DEF * NUM_NEURONS_DEF);
   localparam int D_TAIL_BITS = tail_bits(NUM_INPUTS_DEF);

endpackage

// File: rtl/byte_field_writer.sv
// Flat field register written one byte at a time; the final byte of a field
// whose width is not a multiple of 8 only keeps its low bits.
module byte_field_writer
   import bnn_pkg::*;
#(
   parameter int FIELD_BITS = 196
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [7:0]            byte_idx,
   input  logic [7:0]            byte_data,
   output logic [FIELD_BITS-1:0] field
);

   localparam int NB = bytes_for(FIELD_BITS);

   for (genvar b = 0; b < NB; b++) begin : g_byte
      localparam int LO = 8 * b;
      localparam int W  = ((FIELD_BITS - LO) >= 8) ? 8 : (FIELD_BITS - LO);

      logic [W-1:0] slice_q;

      // Byte slot b: captures the stream byte when the counter points here.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slice_q <= '0;
         end else if (we && (byte_idx == 8'(b))) begin
            slice_q <= byte_data[W-1:0];
         end
      end

      assign field[LO +: W] = slice_q;
   end

endmodule

// File: rtl/layer3_input_loader.sv
// Byte-serial loader for the final classifier layer operands.
//
//   state  | meaning
//   IDLE   | waiting for frame_start, not accepting bytes
//   LOAD_W | streaming weight bytes into the weight matrix
//   LOAD_D | streaming activation bytes into the data vector
//   HOLD   | operands complete and frozen until consume
module layer3_input_loader
   import bnn_pkg::*;
#(
   parameter int NUM_INPUTS  = 196,
   parameter int NUM_NEURONS = 10
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              frame_start,
   input  logic                              load_weights,
   input  logic [7:0]                        byte_in,
   input  logic                              byte_valid,
   output logic                              byte_ready,
   output logic [NUM_INPUTS-1:0]             data_out,
   output logic [NUM_INPUTS*NUM_NEURONS-1:0] weights_out,
   output logic                              vec_valid,
   input  logic                              consume,
   output logic                              frame_abort
);

   localparam int         W_BITS = NUM_INPUTS * NUM_NEURONS;
   localparam logic [7:0] W_LAST = 8'(bytes_for(W_BITS) - 1);
   localparam logic [7:0] D_LAST = 8'(bytes_for(NUM_INPUTS) - 1);

   loader_state_t state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          vec_valid_q;
   logic          abort_q, abort_d;
   logic          xfer;
   logic [7:0]    last_idx;

   assign byte_ready = (state_q == LOAD_W) || (state_q == LOAD_D);
   // A restart in the same cycle as a handshake discards that byte.
   assign xfer       = byte_valid && byte_ready && !frame_start;
   assign last_idx   = (state_q == LOAD_W) ? W_LAST : D_LAST;

   // Next-state, counter and abort-pulse decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = load_weights ? LOAD_W : LOAD_D;
               cnt_d   = 8'd0;
            end
         end
         LOAD_W, LOAD_D: begin
            if (frame_start) begin
               abort_d = 1'b1;
               state_d = load_weights ? LOAD_W : LOAD_D;
               cnt_d   = 8'd0;
            end else if (xfer) begin
               if (cnt_q == last_idx) begin
                  state_d = (state_q == LOAD_W) ? LOAD_D : HOLD;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         HOLD: begin
            if (consume) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter and registered status outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         vec_valid_q <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vec_valid_q <= (state_d == HOLD);
         abort_q     <= abort_d;
      end
   end

   assign vec_valid   = vec_valid_q;
   assign frame_abort = abort_q;

   byte_field_writer #(.FIELD_BITS(W_BITS)) u_w_field (
      .clk       (clock),
      .rst_n     (reset),
      .we        (xfer && (state_q == LOAD_W)),
      .byte_idx  (cnt_q),
      .byte_data (byte_in),
      .field     (weights_out)
   );

   byte_field_writer #(.FIELD_BITS(NUM_INPUTS)) u_d_field (
      .clk       (clock),
      .rst_n     (reset),
      .we        (xfer && (state_q == LOAD_D)),
      .byte_idx  (cnt_q),
      .byte_data (byte_in),
      .field     (data_out)
   );

endmodule

// File: tb/tb_layer3_input_loader.sv
// Scoreboard bench for layer3_input_loader: stimulus pushes the expected
// operands per frame, a negedge monitor checks them when vec_valid rises.
module tb_layer3_input_loader;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          frame_start = 1'b0;
   logic          load_weights = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          byte_valid = 1'b0;
   logic          byte_ready;
   logic [195:0]  data_out;
   logic [1959:0] weights_out;
   logic          vec_valid;
   logic          consume = 1'b0;
   logic          frame_abort;

   layer3_input_loader #(.NUM_INPUTS(196), .NUM_NEURONS(10)) dut (
      .clock        (clock),
      .reset        (reset),
      .frame_start  (frame_start),
      .load_weights (load_weights),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .data_out     (data_out),
      .weights_out  (weights_out),
      .vec_valid    (vec_valid),
      .consume      (consume),
      .frame_abort  (frame_abort)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [195:0]  d;
      logic [1959:0] w;
      int            lat;
   } exp_t;

   exp_t sb_q[$];
   int   start_cyc   = 0;
   int   frames_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: on each vec_valid rise, compare operands and latency.
   exp_t         e;
   logic         vv_prev = 1'b0;
   logic [199:0] dpad, epad;
   int           bad;
   always @(negedge clock) begin
      if (vec_valid === 1'b1 && vv_prev !== 1'b1) begin
         frames_seen++;
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_frame: got vec_valid=1 expected no pending frame");
         end else begin
            e = sb_q.pop_front();
            n_tests++;
            bad = -1;
            for (int k = 244; k >= 0; k--)
               if (weights_out[8*k +: 8] !== e.w[8*k +: 8]) bad = k;
            if (bad >= 0) begin
               n_fail++;
               $display("FAIL sb_weights frame %0d byte %0d: got %0h expected %0h",
                        frames_seen, bad, weights_out[8*bad +: 8], e.w[8*bad +: 8]);
            end
            n_tests++;
            dpad = {4'b0, data_out};
            epad = {4'b0, e.d};
            bad  = -1;
            for (int k = 24; k >= 0; k--)
               if (dpad[8*k +: 8] !== epad[8*k +: 8]) bad = k;
            if (bad >= 0) begin
               n_fail++;
               $display("FAIL sb_data frame %0d byte %0d: got %0h expected %0h",
                        frames_seen, bad, dpad[8*bad +: 8], epad[8*bad +: 8]);
            end
            if (e.lat >= 0) begin
               n_tests++;
               if ((cyc - start_cyc) != e.lat) begin
                  n_fail++;
                  $display("FAIL sb_latency frame %0d: got %0d expected %0d",
                           frames_seen, cyc - start_cyc, e.lat);
               end
            end
         end
      end
      vv_prev = vec_valid;
   end

   // Called at a negedge; leaves at the negedge after frame_start was sampled.
   task automatic start_frame(input logic lw);
      frame_start  = 1'b1;
      load_weights = lw;
      @(negedge clock);
      frame_start = 1'b0;
      start_cyc   = cyc;
   endtask

   // Offers one byte after optional idle cycles; returns at the negedge
   // following the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int bubbles);
      int g;
      repeat (bubbles) begin
         byte_valid = 1'b0;
         @(negedge clock);
      end
      byte_in    = b;
      byte_valid = 1'b1;
      g = 0;
      while (byte_ready !== 1'b1 && g < 50) begin
         @(negedge clock);
         g++;
      end
      if (g >= 50) begin
         n_tests++;
         n_fail++;
         $display("FAIL byte_ready_timeout: got byte_ready=%b expected 1", byte_ready);
      end
      @(negedge clock);
   endtask

   task automatic wait_hold(input string name);
      int g;
      g = 0;
      while (vec_valid !== 1'b1 && g < 20) begin
         @(negedge clock);
         g++;
      end
      chk({name, "_vec_valid"}, 32'(vec_valid), 32'd1);
   endtask

   task automatic release_hold(input string name);
      consume = 1'b1;
      @(negedge clock);
      consume = 1'b0;
      chk({name, "_vec_valid_fall"}, 32'(vec_valid), 32'd0);
   endtask

   logic [1959:0] w_a5, w_x;
   logic [195:0]  d_tmp;
   logic [7:0]    kb;

   initial begin
      w_a5 = {245{8'hA5}};

      repeat (3) @(negedge clock);
      chk("reset_byte_ready", 32'(byte_ready), 32'd0);
      chk("reset_vec_valid", 32'(vec_valid), 32'd0);
      chk("reset_frame_abort", 32'(frame_abort), 32'd0);
      chk("reset_data_zero", 32'(|data_out), 32'd0);
      chk("reset_weights_zero", 32'(|weights_out), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("idle_byte_ready", 32'(byte_ready), 32'd0);

      // Full frame: weights 0xA5, data 0xFF, back-to-back.
      sb_q.push_back('{d: {196{1'b1}}, w: w_a5, lat: 270});
      start_frame(1'b1);
      chk("full_ready_rise", 32'(byte_ready), 32'd1);
      for (int k = 0; k < 245; k++) send_byte(8'hA5, 0);
      for (int k = 0; k < 25; k++) send_byte(8'hFF, 0);
      byte_valid = 1'b0;
      wait_hold("full");
      chk("full_hold_not_ready", 32'(byte_ready), 32'd0);
      release_hold("full");

      // Data-only reload with 0x00; weights retained.
      sb_q.push_back('{d: '0, w: w_a5, lat: 25});
      start_frame(1'b0);
      for (int k = 0; k < 25; k++) send_byte(8'h00, 0);
      byte_valid = 1'b0;
      wait_hold("donly");
      release_hold("donly");

      // Bubbly producer: data byte k = k.
      d_tmp = '0;
      for (int k = 0; k < 25; k++) begin
         kb = 8'(k);
         for (int j = 0; j < 8; j++)
            if (8*k + j < 196) d_tmp[8*k + j] = kb[j];
      end
      sb_q.push_back('{d: d_tmp, w: w_a5, lat: -1});
      start_frame(1'b0);
      for (int k = 0; k < 25; k++) send_byte(8'(k), int'($urandom_range(0, 2)));
      byte_valid = 1'b0;
      wait_hold("bubbly");
      release_hold("bubbly");

      // Abort at data byte 10 with a handshake in the same cycle.
      start_frame(1'b0);
      for (int k = 0; k < 10; k++) send_byte(8'h33, 0);
      d_tmp = '0;
      for (int k = 0; k < 25; k++) begin
         kb = 8'hC0 + 8'(k);
         for (int j = 0; j < 8; j++)
            if (8*k + j < 196) d_tmp[8*k + j] = kb[j];
      end
      sb_q.push_back('{d: d_tmp, w: w_a5, lat: 25});
      byte_in      = 8'hEE;
      byte_valid   = 1'b1;
      frame_start  = 1'b1;
      load_weights = 1'b0;
      @(negedge clock);
      frame_start = 1'b0;
      start_cyc   = cyc;
      chk("abort_pulse", 32'(frame_abort), 32'd1);
      chk("abort_ready", 32'(byte_ready), 32'd1);
      send_byte(8'hC0, 0);
      chk("abort_single_pulse", 32'(frame_abort), 32'd0);
      for (int k = 1; k < 25; k++) send_byte(8'hC0 + 8'(k), 0);
      byte_valid = 1'b0;
      wait_hold("abort");

      // HOLD: frame_start and offered bytes are ignored.
      byte_in     = 8'h55;
      byte_valid  = 1'b1;
      frame_start = 1'b1;
      @(negedge clock);
      frame_start = 1'b0;
      chk("hold_ready_low", 32'(byte_ready), 32'd0);
      chk("hold_vec_valid", 32'(vec_valid), 32'd1);
      chk("hold_no_abort", 32'(frame_abort), 32'd0);
      @(negedge clock);
      chk("hold_vec_valid_2", 32'(vec_valid), 32'd1);
      chk("hold_data_frozen", 32'(data_out[7:0]), 32'hC0);
      consume      = 1'b1;
      frame_start  = 1'b1;
      load_weights = 1'b1;
      @(negedge clock);
      consume     = 1'b0;
      frame_start = 1'b0;
      chk("hold_consume_wins_vv", 32'(vec_valid), 32'd0);
      chk("hold_consume_wins_idle", 32'(byte_ready), 32'd0);
      @(negedge clock);
      chk("hold_stays_idle", 32'(byte_ready), 32'd0);
      byte_valid = 1'b0;

      // Async reset in the middle of LOAD_W.
      start_frame(1'b1);
      for (int k = 0; k < 50; k++) send_byte(8'h5A, 0);
      #2;
      reset      = 1'b0;
      byte_valid = 1'b0;
      #1;
      chk("arst_byte_ready", 32'(byte_ready), 32'd0);
      chk("arst_vec_valid", 32'(vec_valid), 32'd0);
      chk("arst_frame_abort", 32'(frame_abort), 32'd0);
      chk("arst_data_zero", 32'(|data_out), 32'd0);
      chk("arst_weights_zero", 32'(|weights_out), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Full frame after reset: weight byte k = k ^ 0x5A, data 0x81.
      for (int k = 0; k < 245; k++) w_x[8*k +: 8] = 8'(k) ^ 8'h5A;
      sb_q.push_back('{d: {4'b0001, {24{8'h81}}}, w: w_x, lat: 270});
      start_frame(1'b1);
      for (int k = 0; k < 245; k++) send_byte(8'(k) ^ 8'h5A, 0);
      for (int k = 0; k < 25; k++) send_byte(8'h81, 0);
      byte_valid = 1'b0;
      wait_hold("post_reset");
      release_hold("post_reset");

      repeat (3) @(negedge clock);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      chk("frames_seen", 32'(frames_seen), 32'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/layer3_input_loader.md
# layer3_input_loader

Byte-serial loader that fills the final classifier layer's operand registers: the 196-bit binarised activation vector and the 10×196-bit weight matrix. It accepts an 8-bit valid/ready stream from the chip pins or the previous layer, deserialises it into flat vectors, and presents `data_out`/`weights_out` as stable, valid operands. It holds them until the top FSM signals that the result has been consumed. It is the writer-side counterpart of the final-layer popcount/argmax block.

## Interface
Parameters:
- `NUM_INPUTS`, 196: activation bits per neuron.
- `NUM_NEURONS`, 10: output neurons; weight bits = `NUM_INPUTS*NUM_NEURONS`.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse that begins a load frame.
- `load_weights` in 1: sampled with `frame_start`; 1 = weights then data, 0 = data only (weights retained).
- `byte_in` in 8: stream payload.
- `byte_valid` in 1: producer has a byte.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `data_out` out `NUM_INPUTS`: activation vector, feeds the final layer's `data_in`.
- `weights_out` out `NUM_INPUTS*NUM_NEURONS`: weight matrix, feeds `weights_in`.
- `vec_valid` out 1: operands are complete and stable.
- `consume` in 1: pulse from the top FSM after the answer is latched; releases the operands.
- `frame_abort` out 1: one-cycle pulse when a frame is restarted mid-load.

## Operation
- States: IDLE, LOAD_W, LOAD_D, HOLD.
- IDLE: `byte_ready`=0. On `frame_start`, go to LOAD_W if `load_weights`=1, else go to LOAD_D. Clear the byte counter.
- Transfer rule: a byte is accepted only on a rising edge with `byte_valid`&&`byte_ready`. `byte_ready`=1 only in LOAD_W and LOAD_D.
- Bit mapping: byte k, bit j goes to field bit 8k+j (LSB first).
- Partial last byte: only its low `(N mod 8)` bits are written. The upper bits are ignored.
- LOAD_W: 245 bytes (`ceil(1960/8)`). After the last one is accepted, go to LOAD_D with the counter cleared.
- LOAD_D: 25 bytes (`ceil(196/8)`), last byte uses bits [3:0]. After the last one is accepted, go to HOLD.
- HOLD: `vec_valid`=1; `data_out`/`weights_out` are frozen. On `consume`, go to IDLE.
- `vec_valid` is a registered output, driven from the state.
- Register retention:
  - Weight registers are written only in LOAD_W and retain their value otherwise, including across data-only frames.
  - Data registers are written only in LOAD_D.
  - Fields are overwritten in place and are not cleared at frame start.
- Byte counter: 8 bits. Compare against the per-field byte count constant; it never wraps past the count.
- `frame_start` in LOAD_W or LOAD_D: abort the frame.
  - Pulse `frame_abort`.
  - Re-sample `load_weights` and restart the counter in the selected state.
  - A byte handshake in the same cycle is discarded.
- `frame_start` in HOLD: ignored. `consume` outside HOLD: ignored.
- `frame_start` and `consume` both high in HOLD: `consume` wins and the next state is IDLE. A new `frame_start` is needed after that.

## Timing
- Reset values: state IDLE, counter 0, `data_out`=0, `weights_out`=0, `vec_valid`=0, `byte_ready`=0, `frame_abort`=0.
- Reset asserted mid-frame returns immediately to IDLE and clears all registers.
- `byte_ready` rises the cycle after `frame_start`.
- With `byte_valid` held high, throughput is 1 byte/cycle.
- `vec_valid` rises on the edge that accepts the final data byte, so it is visible the cycle after that handshake.
  - Full frame: 270 accepted bytes, plus 1 cycle after `frame_start`.
  - Data-only frame: 25 accepted bytes.
- `byte_ready` drops on the same edge that `vec_valid` rises. A byte offered in that cycle is not taken.
- `vec_valid` falls the cycle after `consume`.
- `frame_abort` is a registered single-cycle pulse, aligned with the restart.

## Structure
- Package `bnn_pkg`:
  - `loader_state_t` enum (IDLE, LOAD_W, LOAD_D, HOLD).
  - `W_BYTES` and `D_BYTES` computed from the parameters.
  - `W_TAIL_BITS` and `D_TAIL_BITS` (`N mod 8`, 0 meaning a full byte).
- One sub-module, `byte_field_writer #(FIELD_BITS)`: the per-field register plus byte-indexed write-enable with tail masking. It is instantiated twice, once for weights and once for data.
- The top module holds the FSM, the counter, and the handshake.

## Test plan
- Full frame: `load_weights`=1, weight bytes 0xA5, data bytes 0xFF, back-to-back.
  - `vec_valid` rises exactly 271 cycles after `frame_start`.
  - Every weight byte is 0xA5 and `data_out` is all ones; tail byte 0xFF writes only bits [195:192].
- Data-only reload after the full frame: `load_weights`=0, data 0x00.
  - `weights_out` is unchanged, `data_out`=0, `vec_valid` after 25 bytes.
- Bubbly producer: `byte_valid` toggles pseudo-randomly.
  - Data byte k=k. Field bit 8k+j equals bit j of k; no byte is lost or duplicated.
- Abort: `frame_start` at data byte 10, with a handshake in the same cycle.
  - `frame_abort` pulses once; that byte is dropped.
  - A fresh 25-byte frame then completes correctly.
- HOLD behaviour:
  - Stimulus: `byte_valid` held 1 and `frame_start` pulsed in HOLD.
  - Required: `byte_ready`=0, no state change. Then `consume` with `frame_start` in the same cycle gives IDLE.
- Async reset mid LOAD_W: all outputs go to 0 immediately, and the next full frame loads correctly.
